// File: rtl/load_store_unit.sv
// Load/store unit: turns a core memory request into one word-wide bus access with
// byte enables, returns extended load data and stalls the core until the access completes.
package load_store_unit_pkg;
  typedef enum logic [3:0] {
    LS_N_A = 4'd0,
    L_B    = 4'd1,
    L_H    = 4'd2,
    L_W    = 4'd3,
    L_BU   = 4'd4,
    L_HU   = 4'd5,
    S_B    = 4'd6,
    S_H    = 4'd7,
    S_W    = 4'd8
  } load_store_type_e;
endpackage

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  load_store_type_e load_store_type_i,
  input  logic             write_enable_i,
  input  logic [XLEN-1:0]  addr_i,
  input  logic [XLEN-1:0]  store_data_i,
  output logic [XLEN-1:0]  load_data_o,
  output logic             done_o,
  output logic             misaligned_o,
  output logic             bus_error_o,
  output logic             mem_req_o,
  input  logic             mem_gnt_i,
  output logic             mem_we_o,
  output logic [3:0]       mem_be_o,
  output logic [XLEN-1:0]  mem_addr_o,
  output logic [XLEN-1:0]  mem_wdata_o,
  input  logic             mem_rvalid_i,
  input  logic [XLEN-1:0]  mem_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e           state_q, state_d;
  load_store_type_e type_q;
  logic [1:0]       off_q;
  logic [XLEN-3:0]  word_addr_q;
  logic [XLEN-1:0]  wdata_q;
  logic [3:0]       be_q;
  logic [CNT_W-1:0] cnt_q;
  logic             misaligned_q;
  logic             bus_error_q;
  logic [XLEN-1:0]  load_data_q;

  logic             accept;
  logic             misaligned_acc;
  logic [3:0]       be_acc;
  logic [XLEN-1:0]  wdata_acc;
  logic             is_store_q;
  logic             timeout;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [XLEN-1:0]  load_ext;

  // The type alone decides load vs. store; write_enable_i is redundant with it.
  assign accept     = (state_q == IDLE) && req_valid_i && (load_store_type_i != LS_N_A);
  assign is_store_q = (type_q == S_B) || (type_q == S_H) || (type_q == S_W);
  assign timeout    = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    be_acc         = 4'b0000;
    misaligned_acc = 1'b0;
    wdata_acc      = store_data_i;
    case (load_store_type_i)
      L_B, L_BU, S_B: be_acc = 4'b0001 << addr_i[1:0];
      L_H, L_HU, S_H: begin
        be_acc         = 4'b0011 << addr_i[1:0];
        misaligned_acc = addr_i[0];
      end
      L_W, S_W: begin
        be_acc         = 4'b1111;
        misaligned_acc = |addr_i[1:0];
      end
      default: ;
    endcase
    case (load_store_type_i)
      S_B:     wdata_acc = {4{store_data_i[7:0]}};
      S_H:     wdata_acc = {2{store_data_i[15:0]}};
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata_i[{off_q, 3'b000} +: 8];
    half_sel = mem_rdata_i[{off_q[1], 4'b0000} +: 16];
    case (type_q)
      L_B:     load_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      L_BU:    load_ext = {{(XLEN-8){1'b0}}, byte_sel};
      L_H:     load_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      L_HU:    load_ext = {{(XLEN-16){1'b0}}, half_sel};
      default: load_ext = mem_rdata_i;
    endcase
  end

  // A grant or response arriving on the last allowed cycle still wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = misaligned_acc ? DONE : REQ;
      REQ: begin
        if (mem_gnt_i)    state_d = WAIT;
        else if (timeout) state_d = DONE;
      end
      WAIT: if (mem_rvalid_i || timeout) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      type_q       <= LS_N_A;
      off_q        <= '0;
      word_addr_q  <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      cnt_q        <= '0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      load_data_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            type_q       <= load_store_type_i;
            off_q        <= addr_i[1:0];
            word_addr_q  <= addr_i[XLEN-1:2];
            wdata_q      <= wdata_acc;
            be_q         <= be_acc;
            cnt_q        <= '0;
            misaligned_q <= misaligned_acc;
            bus_error_q  <= 1'b0;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (!mem_gnt_i && timeout) bus_error_q <= 1'b1;
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (mem_rvalid_i && !is_store_q) load_data_q <= load_ext;
          if (!mem_rvalid_i && timeout)    bus_error_q <= 1'b1;
        end
        DONE: begin
          misaligned_q <= 1'b0;
          bus_error_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign done_o       = (state_q == DONE);
  assign misaligned_o = done_o && misaligned_q;
  assign bus_error_o  = done_o && bus_error_q;
  assign load_data_o  = load_data_q;
  assign mem_req_o    = (state_q == REQ);
  assign mem_we_o     = mem_req_o && is_store_q;
  assign mem_be_o     = mem_req_o ? be_q : 4'b0000;
  assign mem_addr_o   = mem_req_o ? {word_addr_q, 2'b00} : '0;
  assign mem_wdata_o  = mem_req_o ? wdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: extension, lanes, alignment,
// timeout, back-to-back acceptance and reset during an in-flight access.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             req_valid_i;
  logic             req_ready_o;
  load_store_type_e load_store_type_i;
  logic             write_enable_i;
  logic [31:0]      addr_i;
  logic [31:0]      store_data_i;
  logic [31:0]      load_data_o;
  logic             done_o;
  logic             misaligned_o;
  logic             bus_error_o;
  logic             mem_req_o;
  logic             mem_gnt_i;
  logic             mem_we_o;
  logic [3:0]       mem_be_o;
  logic [31:0]      mem_addr_o;
  logic [31:0]      mem_wdata_o;
  logic             mem_rvalid_i;
  logic [31:0]      mem_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(255)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .load_store_type_i(load_store_type_i), .write_enable_i(write_enable_i),
    .addr_i(addr_i), .store_data_i(store_data_i), .load_data_o(load_data_o),
    .done_o(done_o), .misaligned_o(misaligned_o), .bus_error_o(bus_error_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Issues one request with an always-granting memory that answers one cycle after grant.
  // Returns what the bus showed during REQ and the state at the first done_o cycle.
  task automatic do_access(input load_store_type_e t, input logic we, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rd,
                           output logic [31:0] o_addr, output logic [31:0] o_wdata,
                           output logic [3:0] o_be, output logic o_we, output logic o_req,
                           output int lat, output logic [31:0] o_load,
                           output logic o_mis, output logic o_err);
    logic pend;
    pend = 1'b0; o_req = 1'b0; o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b1; load_store_type_i = t; write_enable_i = we;
    addr_i = a; store_data_i = sd; mem_gnt_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0; load_store_type_i = LS_N_A; write_enable_i = 1'b0;
    lat = 1;
    while (!done_o && lat < 20) begin
      mem_rvalid_i = pend;
      mem_rdata_i  = pend ? rd : 32'h0;
      pend = 1'b0;
      if (mem_req_o) begin
        o_req = 1'b1; o_addr = mem_addr_o; o_wdata = mem_wdata_o;
        o_be = mem_be_o; o_we = mem_we_o; pend = 1'b1;
      end
      @(negedge clk_i);
      lat++;
    end
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; mem_gnt_i = 1'b0;
    o_load = load_data_o; o_mis = misaligned_o; o_err = bus_error_o;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if (req_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready_o); end
    n_checks++;
    if ({done_o, misaligned_o, bus_error_o, mem_req_o, mem_we_o} !== 5'b0) begin
      n_fail++; $display("[TB] FAIL reset_flags: got %b expected 00000", {done_o, misaligned_o, bus_error_o, mem_req_o, mem_we_o});
    end
    n_checks++;
    if ({load_data_o, mem_addr_o, mem_wdata_o, mem_be_o} !== 100'b0) begin
      n_fail++; $display("[TB] FAIL reset_buses: load %h addr %h wdata %h be %b expected all zero", load_data_o, mem_addr_o, mem_wdata_o, mem_be_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_load_byte();
    logic [31:0] a, wd, ld; logic [3:0] be; logic we, rq, mis, err; int lat;
    do_access(L_B, 1'b0, 32'h103, 32'h0, 32'h80FF_1234, a, wd, be, we, rq, lat, ld, mis, err);
    n_checks++;
    if (a !== 32'h100) begin n_fail++; $display("[TB] FAIL lb_addr: got %h expected 00000100", a); end
    n_checks++;
    if (be !== 4'b1000 || we !== 1'b0) begin n_fail++; $display("[TB] FAIL lb_be_we: got be %b we %b expected 1000 0", be, we); end
    n_checks++;
    if (ld !== 32'hFFFF_FF80) begin n_fail++; $display("[TB] FAIL lb_data: got %h expected ffffff80", ld); end
    n_checks++;
    if (lat !== 3 || mis !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL lb_latency: got lat %0d mis %b err %b expected 3 0 0", lat, mis, err);
    end
    @(negedge clk_i);
    n_checks++;
    if (done_o !== 1'b0 || req_ready_o !== 1'b1 || load_data_o !== 32'hFFFF_FF80) begin
      n_fail++; $display("[TB] FAIL lb_after: got done %b ready %b data %h expected 0 1 ffffff80", done_o, req_ready_o, load_data_o);
    end
  endtask

  task automatic test_load_half();
    logic [31:0] a, wd, ld; logic [3:0] be; logic we, rq, mis, err; int lat;
    do_access(L_HU, 1'b0, 32'h202, 32'h0, 32'hBEEF_0000, a, wd, be, we, rq, lat, ld, mis, err);
    n_checks++;
    if (be !== 4'b1100 || a !== 32'h200) begin n_fail++; $display("[TB] FAIL lhu_bus: got be %b addr %h expected 1100 00000200", be, a); end
    n_checks++;
    if (ld !== 32'h0000_BEEF) begin n_fail++; $display("[TB] FAIL lhu_data: got %h expected 0000beef", ld); end
    do_access(L_H, 1'b0, 32'h202, 32'h0, 32'hBEEF_0000, a, wd, be, we, rq, lat, ld, mis, err);
    n_checks++;
    if (ld !== 32'hFFFF_BEEF || lat !== 3) begin n_fail++; $display("[TB] FAIL lh_data: got %h lat %0d expected ffffbeef 3", ld, lat); end
  endtask

  task automatic test_store();
    logic [31:0] a, wd, ld; logic [3:0] be; logic we, rq, mis, err; int lat;
    do_access(S_B, 1'b1, 32'h31, 32'hAABB_CC5A, 32'h0, a, wd, be, we, rq, lat, ld, mis, err);
    n_checks++;
    if (we !== 1'b1 || be !== 4'b0010 || a !== 32'h30) begin
      n_fail++; $display("[TB] FAIL sb_bus: got we %b be %b addr %h expected 1 0010 00000030", we, be, a);
    end
    n_checks++;
    if (wd !== 32'h5A5A_5A5A) begin n_fail++; $display("[TB] FAIL sb_wdata: got %h expected 5a5a5a5a", wd); end
    n_checks++;
    if (ld !== 32'hFFFF_BEEF || lat !== 3) begin n_fail++; $display("[TB] FAIL sb_keep_load: got %h lat %0d expected ffffbeef 3", ld, lat); end
    do_access(S_W, 1'b1, 32'h34, 32'hAABB_CC5A, 32'h0, a, wd, be, we, rq, lat, ld, mis, err);
    n_checks++;
    if (be !== 4'b1111 || wd !== 32'hAABB_CC5A || a !== 32'h34) begin
      n_fail++; $display("[TB] FAIL sw_bus: got be %b wdata %h addr %h expected 1111 aabbcc5a 00000034", be, wd, a);
    end
    do_access(S_H, 1'b1, 32'h52, 32'h1234_9876, 32'h0, a, wd, be, we, rq, lat, ld, mis, err);
    n_checks++;
    if (be !== 4'b1100 || wd !== 32'h9876_9876) begin
      n_fail++; $display("[TB] FAIL sh_bus: got be %b wdata %h expected 1100 98769876", be, wd);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] a, wd, ld; logic [3:0] be; logic we, rq, mis, err; int lat;
    do_access(L_W, 1'b0, 32'h42, 32'h0, 32'h1111_1111, a, wd, be, we, rq, lat, ld, mis, err);
    n_checks++;
    if (rq !== 1'b0 || lat !== 1 || mis !== 1'b1 || err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL mis_lw: got req %b lat %0d mis %b err %b expected 0 1 1 0", rq, lat, mis, err);
    end
    n_checks++;
    if (ld !== 32'hFFFF_BEEF) begin n_fail++; $display("[TB] FAIL mis_lw_keep: got %h expected ffffbeef", ld); end
    do_access(S_H, 1'b1, 32'h43, 32'hFFFF_FFFF, 32'h0, a, wd, be, we, rq, lat, ld, mis, err);
    n_checks++;
    if (rq !== 1'b0 || lat !== 1 || mis !== 1'b1) begin
      n_fail++; $display("[TB] FAIL mis_sh: got req %b lat %0d mis %b expected 0 1 1", rq, lat, mis);
    end
    @(negedge clk_i);
    n_checks++;
    if (misaligned_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL mis_pulse: got mis %b done %b expected 0 0", misaligned_o, done_o);
    end
  endtask

  task automatic test_invalid_type();
    int bad;
    bad = 0;
    req_valid_i = 1'b1; load_store_type_i = LS_N_A; addr_i = 32'h60; mem_gnt_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      if (req_ready_o !== 1'b1 || mem_req_o !== 1'b0 || done_o !== 1'b0) bad++;
    end
    req_valid_i = 1'b0; mem_gnt_i = 1'b0;
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("[TB] FAIL ls_n_a_ignored: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_timeout();
    logic [31:0] a, wd, ld; logic [3:0] be; logic we, rq, mis, err; int lat;
    int c, req_drops;
    @(negedge clk_i);
    req_valid_i = 1'b1; load_store_type_i = L_W; addr_i = 32'h80; mem_gnt_i = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b0; load_store_type_i = LS_N_A;
    c = 1; req_drops = 0;
    while (!done_o && c < 300) begin
      if (mem_req_o !== 1'b1) req_drops++;
      @(negedge clk_i);
      c++;
    end
    n_checks++;
    if (c !== 256 || req_drops !== 0) begin
      n_fail++; $display("[TB] FAIL timeout_cycles: got done at %0d with %0d req drops expected 256 and 0", c, req_drops);
    end
    n_checks++;
    if (bus_error_o !== 1'b1 || misaligned_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL timeout_flags: got err %b mis %b req %b expected 1 0 0", bus_error_o, misaligned_o, mem_req_o);
    end
    n_checks++;
    if (load_data_o !== 32'hFFFF_BEEF) begin n_fail++; $display("[TB] FAIL timeout_keep: got %h expected ffffbeef", load_data_o); end
    repeat (44) @(negedge clk_i);
    n_checks++;
    if (mem_req_o !== 1'b0 || done_o !== 1'b0 || req_ready_o !== 1'b1) begin
      n_fail++; $display("[TB] FAIL timeout_idle: got req %b done %b ready %b expected 0 0 1", mem_req_o, done_o, req_ready_o);
    end
    do_access(L_W, 1'b0, 32'h84, 32'h0, 32'hCAFE_F00D, a, wd, be, we, rq, lat, ld, mis, err);
    n_checks++;
    if (ld !== 32'hCAFE_F00D || lat !== 3 || err !== 1'b0 || be !== 4'b1111) begin
      n_fail++; $display("[TB] FAIL after_timeout_lw: got %h lat %0d err %b be %b expected cafef00d 3 0 1111", ld, lat, err, be);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, wd, ld; logic [3:0] be; logic we, rq, mis, err; int lat;
    do_access(L_BU, 1'b1, 32'h101, 32'h0, 32'h0000_9900, a, wd, be, we, rq, lat, ld, mis, err);
    n_checks++;
    if (ld !== 32'h0000_0099 || we !== 1'b0 || be !== 4'b0010) begin
      n_fail++; $display("[TB] FAIL lbu_we_ignored: got %h we %b be %b expected 00000099 0 0010", ld, we, be);
    end
    n_checks++;
    if (req_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL done_not_ready: got %b expected 0", req_ready_o); end
    req_valid_i = 1'b1; load_store_type_i = L_W; addr_i = 32'h300; mem_gnt_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (req_ready_o !== 1'b1 || mem_req_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL b2b_idle: got ready %b req %b done %b expected 1 0 0", req_ready_o, mem_req_o, done_o);
    end
    @(negedge clk_i);
    req_valid_i = 1'b0; load_store_type_i = LS_N_A;
    n_checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h300) begin
      n_fail++; $display("[TB] FAIL b2b_req: got req %b addr %h expected 1 00000300", mem_req_o, mem_addr_o);
    end
    @(negedge clk_i);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1122_3344;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    n_checks++;
    if (done_o !== 1'b1 || load_data_o !== 32'h1122_3344) begin
      n_fail++; $display("[TB] FAIL b2b_done: got done %b data %h expected 1 11223344", done_o, load_data_o);
    end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk_i);
    req_valid_i = 1'b1; load_store_type_i = L_W; addr_i = 32'h10; mem_gnt_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0; load_store_type_i = LS_N_A;
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    n_checks++;
    if (mem_req_o !== 1'b0 || req_ready_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL wait_state: got req %b ready %b expected 0 0", mem_req_o, req_ready_o);
    end
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    n_checks++;
    if (done_o !== 1'b0 || req_ready_o !== 1'b1 || misaligned_o !== 1'b0 || bus_error_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rst_wait_flags: got done %b ready %b mis %b err %b expected 0 1 0 0", done_o, req_ready_o, misaligned_o, bus_error_o);
    end
    n_checks++;
    if (load_data_o !== 32'h0 || mem_req_o !== 1'b0 || mem_be_o !== 4'b0 || mem_addr_o !== 32'h0) begin
      n_fail++; $display("[TB] FAIL rst_wait_data: got data %h req %b be %b addr %h expected 0 0 0 0", load_data_o, mem_req_o, mem_be_o, mem_addr_o);
    end
  endtask

  initial begin
    rst_ni = 1'b0; req_valid_i = 1'b0; load_store_type_i = LS_N_A; write_enable_i = 1'b0;
    addr_i = '0; store_data_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    test_reset();
    test_load_byte();
    test_load_half();
    test_store();
    test_misaligned();
    test_invalid_type();
    test_timeout();
    test_back_to_back();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Executes the data-memory access requested by the core control path.
- Consumes the load/store type, write enable, effective address and store data. Drives a word-wide data-memory bus with byte enables, and returns aligned, sign- or zero-extended load data to the register write-back mux.
- Sits between the execute stage and the data memory in the multi-cycle processor, and stalls the core while an access is in flight.

Parameters:
- XLEN, 32, data and address width; only 32 is supported.
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting for grant or response before the access aborts with an error.

Ports:
- clk_i  input  1  core clock
- rst_ni  input  1  synchronous active-low reset
- req_valid_i  input  1  core presents an access this cycle
- req_ready_o  output  1  unit accepts an access (high only in IDLE)
- load_store_type_i  input  load_store_type_e  L_B, L_H, L_W, L_BU, L_HU, S_B, S_H, S_W or LS_N_A
- write_enable_i  input  1  store request (data_memory_write_enable from control)
- addr_i  input  XLEN  byte address from the ALU
- store_data_i  input  XLEN  rs2 value
- load_data_o  output  XLEN  extended load result for RD_MUX_DMEM
- done_o  output  1  one-cycle pulse when an access completes
- misaligned_o  output  1  one-cycle pulse with done_o on an alignment fault
- bus_error_o  output  1  one-cycle pulse with done_o on timeout
- mem_req_o  output  1  bus request
- mem_gnt_i  input  1  bus grant
- mem_we_o  output  1  bus write
- mem_be_o  output  4  byte enables
- mem_addr_o  output  XLEN  word-aligned address (addr[1:0]=0)
- mem_wdata_o  output  XLEN  lane-shifted store data
- mem_rvalid_i  input  1  response valid (loads and stores)
- mem_rdata_i  input  XLEN  read word

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - state=IDLE.
  - All outputs 0, except req_ready_o=1.
  - load_data_o=0; timeout counter=0.
- Reset takes priority in any state. An in-flight bus transaction is abandoned: mem_req_o drops on the next cycle and a late rvalid is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Accept when req_valid_i=1 and load_store_type_i!=LS_N_A. Latch type, write enable, addr[1:0], word address and store data.
  - LS_N_A with valid: ignored, no done_o.
  - Alignment check on accept: H/HU/S_H need addr[0]=0; W/S_W need addr[1:0]=0.
  - Misaligned: go to DONE with misaligned_o set; no bus activity occurs.
  - Aligned: go to REQ.
- REQ:
  - mem_req_o=1; mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o are held stable until mem_gnt_i=1.
  - On grant: go to WAIT.
  - Grant in the same cycle as the request counts (minimum one cycle in REQ).
- WAIT:
  - mem_req_o=0.
  - On mem_rvalid_i=1: for loads, register the extracted data into load_data_o; go to DONE.
  - rvalid arriving while still in REQ is ignored.
- DONE:
  - done_o=1 for exactly one cycle, together with any error flag; return to IDLE.
  - load_data_o holds its value until the next completed load.
- Timeout:
  - The counter increments each cycle in REQ or WAIT and is cleared on every accept.
  - When it reaches TIMEOUT_CYCLES: go to DONE with bus_error_o=1, mem_req_o=0, load_data_o unchanged.
- Byte enables, where o = addr[1:0]:
  - B: 4'b0001<<o.
  - H: 4'b0011<<o.
  - W: 4'b1111.
  - Loads drive the same mask with mem_we_o=0.
- Store data:
  - S_B replicates byte[7:0] to all four lanes.
  - S_H replicates half[15:0] to both halves.
  - S_W passes through unchanged.
- Load extraction:
  - Select byte rdata[8*o+:8] or half rdata[16*o[1]+:16].
  - L_B/L_H sign-extend; L_BU/L_HU zero-extend; L_W passes through.
- Latency: accept-to-done_o is 3 cycles with immediate grant and rvalid one cycle after grant; misaligned accept-to-done_o is 1 cycle.
- Back-to-back: req_ready_o is 0 in REQ, WAIT and DONE. The next accept is possible on the cycle after DONE.
- write_enable_i must agree with the S_* types. On mismatch, the type governs the access and write_enable_i is ignored.

Test Plan:
- Aligned L_B, addr=0x103, rdata=0x80FF_1234 -> mem_addr_o=0x100, mem_be_o=4'b1000, load_data_o=0xFFFF_FF80, done_o 3 cycles after accept.
- Aligned L_HU, addr=0x202, rdata=0xBEEF_0000 -> mem_be_o=4'b1100, load_data_o=0x0000_BEEF; repeat as L_H -> 0xFFFF_BEEF.
- Aligned S_B, addr=0x31, store_data=0xAABB_CC5A -> mem_we_o=1, mem_be_o=4'b0010, mem_wdata_o=0x5A5A_5A5A; S_W at 0x34 -> be=4'b1111, data unchanged.
- Misaligned L_W at 0x42 and S_H at 0x43 -> mem_req_o never asserts, done_o and misaligned_o pulse together 1 cycle after accept.
- Grant held low for 300 cycles with TIMEOUT_CYCLES=255 -> bus_error_o and done_o pulse after 255 cycles, mem_req_o deasserts, then a fresh L_W completes normally.
- rst_ni asserted during WAIT, then rvalid arrives -> all outputs zero, req_ready_o=1, no done_o, load_data_o=0.
